// File: rtl/ex_stage_seq.sv
`default_nettype none
// ============================================================================
// ex_stage_seq : execute stage - ALU/FPU dispatch, branch resolve, EX/MEM reg
// Revision     : 1.0
// ============================================================================
module ex_stage_seq #(
  parameter int BUS_WIDTH         = 64,
  parameter int REGFILE_LEN       = 6,
  parameter int ALU_CONTROL_WIDTH = 2,
  parameter int ALU_SELECT_WIDTH  = 3,
  parameter int FPU_OP_WIDTH      = 3,
  parameter int FPU_TIMEOUT       = 64
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  input  logic                         in_reg_write,
  input  logic                         in_mem_write,
  input  logic                         in_mem_read,
  input  logic                         in_mem_to_reg,
  input  logic                         in_jump_src,
  input  logic                         in_jalr_src,
  input  logic                         in_u_src,
  input  logic                         in_uj_src,
  input  logic                         in_alu_src,
  input  logic                         in_alu_fpu,
  input  logic                         in_fpu_rd,
  input  logic [2:0]                   in_branch_src,
  input  logic [BUS_WIDTH-1:0]         in_read_data1,
  input  logic [BUS_WIDTH-1:0]         in_read_data2,
  input  logic [BUS_WIDTH-1:0]         in_imm,
  input  logic [BUS_WIDTH-1:0]         in_pc,
  input  logic [REGFILE_LEN-1:0]       in_rd,
  input  logic [ALU_CONTROL_WIDTH-1:0] in_control,
  input  logic [ALU_SELECT_WIDTH-1:0]  in_select,
  input  logic [FPU_OP_WIDTH-1:0]      in_fpu_op,
  input  logic                         flush,
  output logic [BUS_WIDTH-1:0]         alu_a,
  output logic [BUS_WIDTH-1:0]         alu_b,
  output logic [ALU_CONTROL_WIDTH-1:0] alu_control,
  output logic [ALU_SELECT_WIDTH-1:0]  alu_select,
  input  logic [BUS_WIDTH-1:0]         alu_result,
  output logic                         fpu_start,
  output logic                         fpu_abort,
  output logic [BUS_WIDTH-1:0]         fpu_a,
  output logic [BUS_WIDTH-1:0]         fpu_b,
  output logic [FPU_OP_WIDTH-1:0]      fpu_op,
  input  logic                         fpu_done,
  input  logic [BUS_WIDTH-1:0]         fpu_result,
  output logic                         stall,
  output logic                         redirect_valid,
  output logic [BUS_WIDTH-1:0]         redirect_pc,
  output logic                         fpu_timeout_err,
  output logic                         out_valid,
  output logic                         out_reg_write,
  output logic                         out_mem_write,
  output logic                         out_mem_read,
  output logic                         out_mem_to_reg,
  output logic                         out_fpu_rd,
  output logic [BUS_WIDTH-1:0]         out_result,
  output logic [BUS_WIDTH-1:0]         out_store_data,
  output logic [REGFILE_LEN-1:0]       out_rd
);

  localparam int CNT_W = $clog2(FPU_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(FPU_TIMEOUT - 1);

  typedef enum logic [0:0] {S_RUN = 1'b0, S_WAIT = 1'b1} state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [CNT_W-1:0]        r_cnt;
  logic                    w_live;
  logic                    w_taken;
  logic                    w_redirect;
  logic                    w_capture_run;
  logic                    w_capture_fpu;
  logic                    w_timeout;
  logic [BUS_WIDTH-1:0]    w_rs1_imm;
  logic [BUS_WIDTH-1:0]    w_pc_imm;
  logic [BUS_WIDTH-1:0]    w_target;
  logic [BUS_WIDTH-1:0]    w_result;

  // FPU instruction's writeback controls, held while the FPU works
  logic                    r_pend_reg_write;
  logic                    r_pend_mem_write;
  logic                    r_pend_mem_read;
  logic                    r_pend_mem_to_reg;
  logic                    r_pend_fpu_rd;
  logic [REGFILE_LEN-1:0]  r_pend_rd;
  logic [BUS_WIDTH-1:0]    r_pend_store;

  assign alu_a       = in_read_data1;
  assign alu_b       = in_alu_src ? in_imm : in_read_data2;
  assign alu_control = in_control;
  assign alu_select  = in_select;
  assign fpu_a       = in_read_data1;
  assign fpu_b       = in_read_data2;
  assign fpu_op      = in_fpu_op;

  // redirect_valid doubles as the squash of the wrong-path instruction
  assign w_live    = in_valid & ~redirect_valid & ~flush;
  assign w_rs1_imm = in_read_data1 + in_imm;
  assign w_pc_imm  = in_pc + in_imm;

  always_comb begin
    w_taken = 1'b0;
    case (in_branch_src)
      3'b001:  w_taken = (in_read_data1 == in_read_data2);
      3'b010:  w_taken = (in_read_data1 != in_read_data2);
      3'b011:  w_taken = ($signed(in_read_data1) <  $signed(in_read_data2));
      3'b100:  w_taken = ($signed(in_read_data1) >= $signed(in_read_data2));
      3'b101:  w_taken = (in_read_data1 <  in_read_data2);
      3'b110:  w_taken = (in_read_data1 >= in_read_data2);
      default: w_taken = 1'b0;
    endcase
  end

  assign w_redirect = in_jalr_src | in_jump_src | w_taken;
  assign w_target   = in_jalr_src ? {w_rs1_imm[BUS_WIDTH-1:1], 1'b0} : w_pc_imm;

  always_comb begin
    w_result = alu_result;
    if (in_jump_src || in_jalr_src) w_result = in_pc + BUS_WIDTH'(4);
    else if (in_u_src)              w_result = in_imm;
    else if (in_uj_src)             w_result = w_pc_imm;
    else if (in_alu_fpu)            w_result = fpu_result;
  end

  always_comb begin
    w_state_next  = r_state;
    stall         = 1'b0;
    fpu_start     = 1'b0;
    fpu_abort     = 1'b0;
    w_capture_run = 1'b0;
    w_capture_fpu = 1'b0;
    w_timeout     = 1'b0;
    case (r_state)
      S_RUN: begin
        if (w_live && in_alu_fpu) begin
          fpu_start    = 1'b1;
          stall        = 1'b1;
          w_state_next = S_WAIT;
        end else if (w_live) begin
          w_capture_run = 1'b1;
        end
      end
      S_WAIT: begin
        // flush beats a same-cycle done; done beats the timeout
        if (flush) begin
          fpu_abort    = 1'b1;
          w_state_next = S_RUN;
        end else if (fpu_done) begin
          w_capture_fpu = 1'b1;
          w_state_next  = S_RUN;
        end else if (r_cnt == C_CNT_LAST) begin
          fpu_abort    = 1'b1;
          w_timeout    = 1'b1;
          w_state_next = S_RUN;
        end else begin
          stall = 1'b1;
        end
      end
      default: w_state_next = S_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state           <= S_RUN;
      r_cnt             <= '0;
      redirect_valid    <= 1'b0;
      redirect_pc       <= '0;
      fpu_timeout_err   <= 1'b0;
      out_valid         <= 1'b0;
      out_reg_write     <= 1'b0;
      out_mem_write     <= 1'b0;
      out_mem_read      <= 1'b0;
      out_mem_to_reg    <= 1'b0;
      out_fpu_rd        <= 1'b0;
      out_result        <= '0;
      out_store_data    <= '0;
      out_rd            <= '0;
      r_pend_reg_write  <= 1'b0;
      r_pend_mem_write  <= 1'b0;
      r_pend_mem_read   <= 1'b0;
      r_pend_mem_to_reg <= 1'b0;
      r_pend_fpu_rd     <= 1'b0;
      r_pend_rd         <= '0;
      r_pend_store      <= '0;
    end else begin
      r_state        <= w_state_next;
      r_cnt          <= (r_state == S_WAIT) ? r_cnt + 1'b1 : '0;
      redirect_valid <= w_capture_run & w_redirect;
      if (w_capture_run && w_redirect) redirect_pc <= w_target;
      if (w_timeout) fpu_timeout_err <= 1'b1;

      if (fpu_start) begin
        r_pend_reg_write  <= in_reg_write;
        r_pend_mem_write  <= in_mem_write;
        r_pend_mem_read   <= in_mem_read;
        r_pend_mem_to_reg <= in_mem_to_reg;
        r_pend_fpu_rd     <= in_fpu_rd;
        r_pend_rd         <= in_rd;
        r_pend_store      <= in_read_data2;
      end

      if (w_capture_run) begin
        out_valid      <= 1'b1;
        out_reg_write  <= in_reg_write;
        out_mem_write  <= in_mem_write;
        out_mem_read   <= in_mem_read;
        out_mem_to_reg <= in_mem_to_reg;
        out_fpu_rd     <= in_fpu_rd;
        out_result     <= w_result;
        out_store_data <= in_read_data2;
        out_rd         <= in_rd;
      end else if (w_capture_fpu) begin
        out_valid      <= 1'b1;
        out_reg_write  <= r_pend_reg_write;
        out_mem_write  <= r_pend_mem_write;
        out_mem_read   <= r_pend_mem_read;
        out_mem_to_reg <= r_pend_mem_to_reg;
        out_fpu_rd     <= r_pend_fpu_rd;
        out_result     <= fpu_result;
        out_store_data <= r_pend_store;
        out_rd         <= r_pend_rd;
      end else begin
        out_valid      <= 1'b0;
        out_reg_write  <= 1'b0;
        out_mem_write  <= 1'b0;
        out_mem_read   <= 1'b0;
        out_mem_to_reg <= 1'b0;
        out_fpu_rd     <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ex_stage_seq.sv
`default_nettype none
// ============================================================================
// tb_ex_stage_seq : scoreboard bench for ex_stage_seq with ALU/FPU models
// Revision        : 1.0
// ============================================================================
module tb_ex_stage_seq;

  localparam int TMO = 8;

  typedef struct packed {
    logic        valid, reg_write, mem_write, mem_read, mem_to_reg;
    logic        jump, jalr, u, uj, alu_src, fpu, fpu_rd;
    logic [2:0]  branch;
    logic [63:0] rs1, rs2, imm, pc;
    logic [5:0]  rd;
    logic [1:0]  ctrl;
    logic [2:0]  sel;
    logic [2:0]  fop;
  } instr_t;

  typedef struct packed {
    logic [63:0] result;
    logic [63:0] store;
    logic [5:0]  rd;
    logic [4:0]  ctl;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid, in_reg_write, in_mem_write, in_mem_read, in_mem_to_reg;
  logic in_jump_src, in_jalr_src, in_u_src, in_uj_src, in_alu_src, in_alu_fpu, in_fpu_rd;
  logic [2:0]  in_branch_src;
  logic [63:0] in_read_data1, in_read_data2, in_imm, in_pc;
  logic [5:0]  in_rd;
  logic [1:0]  in_control;
  logic [2:0]  in_select, in_fpu_op;
  logic        flush;
  logic [63:0] alu_a, alu_b, alu_result;
  logic [1:0]  alu_control;
  logic [2:0]  alu_select;
  logic        fpu_start, fpu_abort, fpu_done;
  logic [63:0] fpu_a, fpu_b, fpu_result;
  logic [2:0]  fpu_op;
  logic        stall, redirect_valid, fpu_timeout_err;
  logic [63:0] redirect_pc;
  logic        out_valid, out_reg_write, out_mem_write, out_mem_read, out_mem_to_reg, out_fpu_rd;
  logic [63:0] out_result, out_store_data;
  logic [5:0]  out_rd;

  int   checks = 0;
  int   failures = 0;
  logic squash = 1'b0;
  logic exp_terr = 1'b0;
  exp_t exp_q[$];
  logic [63:0] rdr_q[$];

  ex_stage_seq #(.FPU_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .in_reg_write(in_reg_write), .in_mem_write(in_mem_write), .in_mem_read(in_mem_read),
    .in_mem_to_reg(in_mem_to_reg), .in_jump_src(in_jump_src), .in_jalr_src(in_jalr_src),
    .in_u_src(in_u_src), .in_uj_src(in_uj_src), .in_alu_src(in_alu_src),
    .in_alu_fpu(in_alu_fpu), .in_fpu_rd(in_fpu_rd), .in_branch_src(in_branch_src),
    .in_read_data1(in_read_data1), .in_read_data2(in_read_data2), .in_imm(in_imm),
    .in_pc(in_pc), .in_rd(in_rd), .in_control(in_control), .in_select(in_select),
    .in_fpu_op(in_fpu_op), .flush(flush), .alu_a(alu_a), .alu_b(alu_b),
    .alu_control(alu_control), .alu_select(alu_select), .alu_result(alu_result),
    .fpu_start(fpu_start), .fpu_abort(fpu_abort), .fpu_a(fpu_a), .fpu_b(fpu_b),
    .fpu_op(fpu_op), .fpu_done(fpu_done), .fpu_result(fpu_result), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fpu_timeout_err(fpu_timeout_err), .out_valid(out_valid),
    .out_reg_write(out_reg_write), .out_mem_write(out_mem_write),
    .out_mem_read(out_mem_read), .out_mem_to_reg(out_mem_to_reg),
    .out_fpu_rd(out_fpu_rd), .out_result(out_result),
    .out_store_data(out_store_data), .out_rd(out_rd)
  );

  always #5 clk = ~clk;

  // Behavioural external ALU: an operation chosen by control, offset by select
  function automatic logic [63:0] alu_fn(logic [1:0] c, logic [2:0] s, logic [63:0] a, logic [63:0] b);
    logic [63:0] r;
    case (c)
      2'd0:    r = a + b;
      2'd1:    r = a - b;
      2'd2:    r = a ^ b;
      default: r = a & b;
    endcase
    return r + 64'(s);
  endfunction

  assign alu_result = alu_fn(alu_control, alu_select, alu_a, alu_b);

  function automatic logic taken_fn(instr_t i);
    case (i.branch)
      3'd1:    return i.rs1 == i.rs2;
      3'd2:    return i.rs1 != i.rs2;
      3'd3:    return $signed(i.rs1) <  $signed(i.rs2);
      3'd4:    return $signed(i.rs1) >= $signed(i.rs2);
      3'd5:    return i.rs1 <  i.rs2;
      3'd6:    return i.rs1 >= i.rs2;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [63:0] exp_result(instr_t i);
    if (i.jump || i.jalr) return i.pc + 64'd4;
    if (i.u)              return i.imm;
    if (i.uj)             return i.pc + i.imm;
    return alu_fn(i.ctrl, i.sel, i.rs1, i.alu_src ? i.imm : i.rs2);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input instr_t i);
    in_valid = i.valid; in_reg_write = i.reg_write; in_mem_write = i.mem_write;
    in_mem_read = i.mem_read; in_mem_to_reg = i.mem_to_reg; in_jump_src = i.jump;
    in_jalr_src = i.jalr; in_u_src = i.u; in_uj_src = i.uj; in_alu_src = i.alu_src;
    in_alu_fpu = i.fpu; in_fpu_rd = i.fpu_rd; in_branch_src = i.branch;
    in_read_data1 = i.rs1; in_read_data2 = i.rs2; in_imm = i.imm; in_pc = i.pc;
    in_rd = i.rd; in_control = i.ctrl; in_select = i.sel; in_fpu_op = i.fop;
  endtask

  function automatic instr_t rand_instr();
    instr_t i;
    i = '0;
    i.valid = ($urandom_range(0, 7) != 0);
    i.reg_write = 1'($urandom); i.mem_write = 1'($urandom); i.mem_read = 1'($urandom);
    i.mem_to_reg = 1'($urandom); i.alu_src = 1'($urandom); i.fpu_rd = 1'($urandom);
    i.rs1 = {$urandom, $urandom};
    i.rs2 = ($urandom_range(0, 3) == 0) ? i.rs1 : {$urandom, $urandom};
    i.imm = {$urandom, $urandom}; i.pc = {$urandom, $urandom};
    i.rd = 6'($urandom); i.ctrl = 2'($urandom); i.sel = 3'($urandom); i.fop = 3'($urandom);
    case ($urandom_range(0, 9))
      0:       i.jump = 1'b1;
      1:       i.jalr = 1'b1;
      2:       i.u = 1'b1;
      3:       i.uj = 1'b1;
      4, 5:    i.branch = 3'($urandom_range(1, 7));
      6:       i.fpu = 1'b1;
      default: i.branch = 3'd0;
    endcase
    return i;
  endfunction

  // One ID/EX instruction; FPU ops are followed through every WAIT cycle.
  // fl_at: 0 = flush in the issue cycle, k+1 = flush in WAIT cycle k, -1 = none
  task automatic step(input instr_t ins, input int lat, input int fl_at, input logic [63:0] fres);
    logic live;
    exp_t e;
    @(negedge clk);
    drive(ins);
    flush = (fl_at == 0);
    fpu_done = ($urandom_range(0, 3) == 0);
    fpu_result = {$urandom, $urandom};
    #1;
    live = ins.valid && !squash && !flush;
    chk("stall_issue", stall, live && ins.fpu);
    chk("fpu_start_issue", fpu_start, live && ins.fpu);
    chk("fpu_abort_issue", fpu_abort, 0);
    squash = 1'b0;
    e.store = ins.rs2;
    e.rd = ins.rd;
    e.ctl = {ins.reg_write, ins.mem_write, ins.mem_read, ins.mem_to_reg, ins.fpu_rd};
    if (live && !ins.fpu) begin
      e.result = exp_result(ins);
      exp_q.push_back(e);
      if (ins.jalr) begin
        rdr_q.push_back((ins.rs1 + ins.imm) & ~64'd1);
        squash = 1'b1;
      end else if (ins.jump || taken_fn(ins)) begin
        rdr_q.push_back(ins.pc + ins.imm);
        squash = 1'b1;
      end
    end else if (live) begin
      chk("fpu_a", fpu_a, ins.rs1);
      chk("fpu_b", fpu_b, ins.rs2);
      chk("fpu_op", fpu_op, ins.fop);
      for (int k = 0; k < TMO; k++) begin
        @(negedge clk);
        flush = (fl_at == k + 1);
        fpu_done = (k == lat - 1);
        fpu_result = fres;
        #1;
        chk("fpu_start_wait", fpu_start, 0);
        if (flush) begin
          chk("fpu_abort_flush", fpu_abort, 1);
          break;
        end else if (fpu_done) begin
          chk("stall_done", stall, 0);
          chk("fpu_abort_done", fpu_abort, 0);
          e.result = fres;
          exp_q.push_back(e);
          break;
        end else if (k == TMO - 1) begin
          chk("fpu_abort_timeout", fpu_abort, 1);
          chk("stall_timeout", stall, 0);
          exp_terr = 1'b1;
        end else begin
          chk("stall_wait", stall, 1);
          chk("fpu_abort_wait", fpu_abort, 0);
        end
      end
    end
  endtask

  // Scoreboard monitor: pops an expectation for every EX/MEM or redirect pulse
  initial begin
    exp_t e;
    logic [63:0] pc;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n) begin
        chk("fpu_timeout_err", fpu_timeout_err, exp_terr);
        if (out_valid) begin
          if (exp_q.size() == 0) chk("out_valid_unexpected", out_valid, 0);
          else begin
            e = exp_q.pop_front();
            chk("out_result", out_result, e.result);
            chk("out_store_data", out_store_data, e.store);
            chk("out_rd", out_rd, e.rd);
            chk("out_ctl", {out_reg_write, out_mem_write, out_mem_read, out_mem_to_reg, out_fpu_rd}, e.ctl);
          end
        end
        if (redirect_valid) begin
          if (rdr_q.size() == 0) chk("redirect_unexpected", redirect_valid, 0);
          else begin
            pc = rdr_q.pop_front();
            chk("redirect_pc", redirect_pc, pc);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    instr_t i;
    instr_t idle;
    int lat;
    int fl;
    idle = '0;
    drive(idle);
    flush = 1'b0; fpu_done = 1'b0; fpu_result = '0;
    repeat (3) @(negedge clk);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_result", out_result, 0);
    chk("reset_redirect_valid", redirect_valid, 0);
    chk("reset_redirect_pc", redirect_pc, 0);
    chk("reset_timeout_err", fpu_timeout_err, 0);
    chk("reset_stall", stall, 0);
    rst_n = 1'b1;

    // add with immediate: 5 + 7
    i = '0; i.valid = 1'b1; i.reg_write = 1'b1; i.alu_src = 1'b1;
    i.rs1 = 64'd5; i.imm = 64'd7; i.rd = 6'd3;
    step(i, 0, -1, '0);
    // bne taken to 0x120, then a squashed instruction, then beq not taken
    i = '0; i.valid = 1'b1; i.branch = 3'd2; i.rs1 = 64'd1; i.rs2 = 64'd2;
    i.pc = 64'h100; i.imm = 64'h20;
    step(i, 0, -1, '0);
    i.branch = 3'd0; i.reg_write = 1'b1; i.rd = 6'd9;
    step(i, 0, -1, '0);
    i.branch = 3'd1; i.reg_write = 1'b0;
    step(i, 0, -1, '0);
    // jalr: target 0x206, link 0x44
    i = '0; i.valid = 1'b1; i.jalr = 1'b1; i.reg_write = 1'b1; i.rd = 6'd1;
    i.rs1 = 64'h203; i.imm = 64'd4; i.pc = 64'h40;
    step(i, 0, -1, '0);
    step(idle, 0, -1, '0);
    // FPU: done three cycles after start with 0xABCD
    i = '0; i.valid = 1'b1; i.fpu = 1'b1; i.fpu_rd = 1'b1; i.reg_write = 1'b1;
    i.rd = 6'd12; i.rs1 = 64'h11; i.rs2 = 64'h22; i.fop = 3'd5;
    step(i, 3, -1, 64'hABCD);
    // FPU timeout, then flush colliding with done
    step(i, 1000, -1, 64'h1);
    step(i, 4, 4, 64'h2);
    step(idle, 0, -1, '0);

    // asynchronous reset in the middle of a WAIT
    @(negedge clk);
    drive(i); flush = 1'b0; fpu_done = 1'b0;
    #1;
    chk("rst_test_start", fpu_start, 1);
    @(negedge clk);
    #1;
    chk("rst_test_stall_wait", stall, 1);
    #2;
    rst_n = 1'b0;
    in_valid = 1'b0;
    exp_terr = 1'b0;
    squash = 1'b0;
    #1;
    chk("async_rst_out_valid", out_valid, 0);
    chk("async_rst_out_result", out_result, 0);
    chk("async_rst_stall", stall, 0);
    chk("async_rst_abort", fpu_abort, 0);
    chk("async_rst_timeout_err", fpu_timeout_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    i = '0; i.valid = 1'b1; i.reg_write = 1'b1; i.rs1 = 64'd40; i.rs2 = 64'd2; i.rd = 6'd7;
    step(i, 0, -1, '0);

    for (int n = 0; n < 400; n++) begin
      lat = ($urandom_range(0, 7) == 0) ? 1000 : $urandom_range(1, 6);
      fl = ($urandom_range(0, 11) == 0) ? $urandom_range(0, 4) : -1;
      step(rand_instr(), lat, fl, {$urandom, $urandom});
    end
    repeat (3) step(idle, 0, -1, '0);
    @(negedge clk);
    chk("exp_q_drained", exp_q.size(), 0);
    chk("rdr_q_drained", rdr_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ex_stage_seq.md
Name: ex_stage_seq

Overview:
- Execute stage that consumes the ID/EX pipeline register outputs and produces the EX/MEM register contents.
- Drives the external combinational ALU and the external multi-cycle FPU.
- Resolves branches and jumps, stalls upstream while an FPU op is in flight, and issues a one-cycle PC redirect on taken control flow.

Parameters:
BUS_WIDTH, 64, data/address width
REGFILE_LEN, 6, destination register index width
ALU_CONTROL_WIDTH, 2, ALU control width
ALU_SELECT_WIDTH, 3, ALU select width
FPU_OP_WIDTH, 3, FPU opcode width
FPU_TIMEOUT, 64, maximum FPU wait cycles before abort

Ports:
clk  in  1  clock
rst_n  in  1  reset
in_valid  in  1  ID/EX holds a live instruction
in_reg_write, in_mem_write, in_mem_read, in_mem_to_reg, in_jump_src, in_jalr_src, in_u_src, in_uj_src, in_alu_src, in_alu_fpu, in_fpu_rd  in  1 each  decoded controls
in_branch_src  in  3  000 none, 001 beq, 010 bne, 011 blt, 100 bge, 101 bltu, 110 bgeu
in_read_data1, in_read_data2, in_imm, in_pc  in  BUS_WIDTH  operands, immediate, PC
in_rd  in  REGFILE_LEN  destination register
in_control  in  ALU_CONTROL_WIDTH  ALU control, passed to alu_control
in_select  in  ALU_SELECT_WIDTH  ALU select, passed to alu_select
in_fpu_op  in  FPU_OP_WIDTH  FPU opcode
flush  in  1  kill in-flight EX work (trap or later stage)
alu_a, alu_b  out  BUS_WIDTH  ALU operands
alu_control  out  ALU_CONTROL_WIDTH  ALU control
alu_select  out  ALU_SELECT_WIDTH  ALU select
alu_result  in  BUS_WIDTH  combinational ALU result
fpu_start  out  1  one-cycle FPU launch pulse
fpu_abort  out  1  one-cycle FPU cancel pulse
fpu_a, fpu_b  out  BUS_WIDTH  FPU operands
fpu_op  out  FPU_OP_WIDTH  FPU opcode
fpu_done  in  1  FPU result valid, single-cycle
fpu_result  in  BUS_WIDTH  FPU result
stall  out  1  hold IF/ID and ID/EX
redirect_valid  out  1  registered one-cycle redirect pulse
redirect_pc  out  BUS_WIDTH  redirect target
fpu_timeout_err  out  1  sticky FPU timeout flag
out_valid, out_reg_write, out_mem_write, out_mem_read, out_mem_to_reg, out_fpu_rd  out  1 each  EX/MEM controls
out_result, out_store_data  out  BUS_WIDTH  EX/MEM result, rs2 data
out_rd  out  REGFILE_LEN  EX/MEM destination register

Behaviour:
- Reset (rst_n low, asynchronous):
  - All registered outputs clear to 0.
  - FSM enters RUN; timeout counter clears to 0.
- ALU operands: alu_a = in_read_data1; alu_b = in_alu_src ? in_imm : in_read_data2; alu_control = in_control; alu_select = in_select; all combinational.
- Result select, priority order:
  1. jump_src or jalr_src: pc+4.
  2. u_src (lui): imm.
  3. uj_src (auipc): pc+imm.
  4. alu_fpu: fpu_result.
  5. Otherwise: alu_result.
- All arithmetic is modulo 2^BUS_WIDTH.
- Branch compare on rs1/rs2: signed for blt/bge, unsigned for bltu/bgeu.
- Redirect targets:
  - jalr: (rs1+imm) with bit0 cleared.
  - jal or taken branch: pc+imm.
- "live" = in_valid & ~squash & ~flush.
- squash is asserted in the cycle redirect_valid=1; it kills the wrong-path instruction in ID/EX.
- FSM RUN:
  - live & ~alu_fpu: EX/MEM captures at the next edge with out_valid=1.
  - redirect_valid/redirect_pc are registered from the same instruction (1-cycle pulse).
  - live & alu_fpu: fpu_start=1 and stall=1 combinationally; at the edge go WAIT, out_valid<=0, counter<=0.
  - Not live: out_valid<=0, and all EX/MEM write-enable controls <=0.
- FSM WAIT:
  - stall=1 while ~fpu_done; the counter increments each cycle.
  - fpu_done: stall=0 that cycle; EX/MEM captures fpu_result with out_valid=1; go RUN.
  - Counter reaches FPU_TIMEOUT-1 without done: fpu_abort=1, fpu_timeout_err<=1 (sticky until reset), out_valid<=0, go RUN, stall drops that cycle.
  - flush: fpu_abort=1, out_valid<=0, go RUN; flush wins over fpu_done in the same cycle.
- fpu_start and fpu_abort are never asserted together.
- fpu_done while in RUN is ignored.
- FPU instructions never redirect.
- Stall never blocks the EX/MEM update.
- Reset mid-WAIT returns to RUN with no fpu_abort pulse; the FPU is reset by the same rst_n.

Test Plan:
- ALU: add, in_alu_src=1, rs1=5, imm=7, alu_result=12 -> next cycle out_valid=1, out_result=12, stall=0 throughout.
- Branch: bne, rs1=1, rs2=2, pc=0x100, imm=0x20 -> redirect_valid=1 for exactly one cycle with redirect_pc=0x120; following in_valid instruction squashed (out_valid=0); beq with same operands -> no redirect.
- jalr: rs1=0x203, imm=4, pc=0x40 -> redirect_pc=0x206, out_result=0x44.
- FPU: fpu_done returned 3 cycles after start with result 0xABCD -> fpu_start single pulse; stall high 3 cycles, low in the done cycle; out_valid=1, out_result=0xABCD next edge.
- Timeout: FPU_TIMEOUT=8, fpu_done never asserted -> fpu_abort at 8th stall cycle, fpu_timeout_err=1 sticky, out_valid=0; flush in the same cycle as fpu_done -> out_valid=0, fpu_abort=1.
- Async reset asserted mid-WAIT, off clock edge -> outputs zero immediately, stall=0, FSM in RUN after release.
